// File: rtl/cmd_arbiter.sv
// cmd_arbiter: round-robin arbiter that hands one queued command at a time to an accelerator.
// Optional watchdog is compiled in with `define CMD_ARB_TIMEOUT_EN.
module cmd_arbiter #(
    parameter int          NUM_REQ        = 4,
    parameter int          CMD_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    localparam int         ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_REQ-1:0]           req_empty,
    input  logic [NUM_REQ*CMD_WIDTH-1:0] req_din,
    output logic [NUM_REQ-1:0]           req_read,
    input  logic                         args_ready,
    output logic                         ap_start,
    input  logic                         ap_ready,
    input  logic                         ap_done,
    output logic [CMD_WIDTH-1:0]         cmd_out,
    output logic [ID_W-1:0]              grant_id,
    output logic [NUM_REQ-1:0]           req_done,
    output logic                         busy,
    output logic                         timeout_err
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_ARGS  = 2'd1,
        WAIT_READY = 2'd2,
        WAIT_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]        grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0]     req_read_q, req_read_d;
    logic [NUM_REQ-1:0]     req_done_q, req_done_d;
    logic                   ap_start_q, ap_start_d;
    logic [CMD_WIDTH-1:0]   cmd_q, cmd_d;
    logic [ID_W-1:0]        pick;
    logic                   pick_valid;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        return ID_W'((int'(base) + off) % NUM_REQ);
    endfunction

    // Scan downward so the closest non-empty requester at or after rr_ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (!req_empty[wrap_idx(rr_ptr_q, k)]) begin
                pick_valid = 1'b1;
                pick       = wrap_idx(rr_ptr_q, k);
            end
        end
    end

`ifdef CMD_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        timeout_err_q, timeout_err_d;
`endif

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        cmd_d      = cmd_q;
        ap_start_d = ap_start_q;
        req_read_d = '0;
        req_done_d = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    req_read_d[pick] = 1'b1;
                    cmd_d            = req_din[int'(pick)*CMD_WIDTH +: CMD_WIDTH];
                    grant_id_d       = pick;
                    rr_ptr_d         = (pick == ID_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
                    state_d          = WAIT_ARGS;
                end
            end
            WAIT_ARGS: begin
                if (args_ready) begin
                    ap_start_d = 1'b1;
                    state_d    = WAIT_READY;
                end
            end
            WAIT_READY: begin
                if (ap_ready) begin
                    ap_start_d = 1'b0;
                    if (ap_done) begin
                        req_done_d[grant_id_q] = 1'b1;
                        state_d                = IDLE;
                    end else begin
                        state_d = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (ap_done) begin
                    req_done_d[grant_id_q] = 1'b1;
                    state_d                = IDLE;
                end
            end
            default: begin
                ap_start_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
`ifdef CMD_ARB_TIMEOUT_EN
        // An expired watchdog overrides any handshake seen on the same edge.
        wd_cnt_d      = wd_cnt_q;
        timeout_err_d = timeout_err_q;
        if (state_q == WAIT_ARGS && state_d == WAIT_READY) begin
            wd_cnt_d = '0;
        end else if (state_q == WAIT_READY || state_q == WAIT_DONE) begin
            wd_cnt_d = wd_cnt_q + 16'd1;
            if (wd_cnt_q == TIMEOUT_LIMIT) begin
                state_d       = IDLE;
                ap_start_d    = 1'b0;
                req_done_d    = '0;
                timeout_err_d = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            cmd_q      <= '0;
            ap_start_q <= 1'b0;
            req_read_q <= '0;
            req_done_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            cmd_q      <= cmd_d;
            ap_start_q <= ap_start_d;
            req_read_q <= req_read_d;
            req_done_q <= req_done_d;
        end
    end

`ifdef CMD_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_LIMIT;
    assign timeout_err    = 1'b0;
`endif

    assign req_read = req_read_q;
    assign req_done = req_done_q;
    assign ap_start = ap_start_q;
    assign cmd_out  = cmd_q;
    assign grant_id = grant_id_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: doc/cmd_arbiter.md
CMD_ARBITER -- requirements
Module: cmd_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, the number of command-queue requesters (1..16).
REQ-002 The block SHALL have parameter CMD_WIDTH, default 32, the command word width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 65535, the watchdog limit, 16-bit, used only with CMD_ARB_TIMEOUT_EN.
REQ-004 The block SHALL define localparam ID_W = max(1, clog2(NUM_REQ)).
REQ-005 The block SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-007 The block SHALL have port req_empty  input  NUM_REQ  per-requester first-word-fall-through command FIFO empty flag.
REQ-008 The block SHALL have port req_din  input  NUM_REQ*CMD_WIDTH  per-requester FIFO head word; slice i is bits [i*CMD_WIDTH +: CMD_WIDTH].
REQ-009 The block SHALL have port req_read  output  NUM_REQ  one-hot dequeue strobe.
REQ-010 The block SHALL have port args_ready  input  1  all accelerator arguments are available.
REQ-011 The block SHALL have port ap_start  output  1  accelerator start, held until ap_ready.
REQ-012 The block SHALL have port ap_ready  input  1  accelerator has accepted the start.
REQ-013 The block SHALL have port ap_done  input  1  accelerator job is complete.
REQ-014 The block SHALL have port cmd_out  output  CMD_WIDTH  latched command of the granted job.
REQ-015 The block SHALL have port grant_id  output  ID_W  index of the granted requester.
REQ-016 The block SHALL have port req_done  output  NUM_REQ  one-cycle completion pulse to the owning requester.
REQ-017 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-018 The block SHALL have port timeout_err  output  1  sticky watchdog error flag.

Function
REQ-019 The state machine SHALL have the states IDLE, WAIT_ARGS, WAIT_READY and WAIT_DONE; any illegal state SHALL go to IDLE.
REQ-020 In IDLE, with any req_empty bit low, the block SHALL grant g = the first non-empty index searching upward from rr_ptr with wrap-around.
REQ-021 On the grant edge, the block SHALL register req_read[g]=1 for one cycle, set cmd_out to the req_din slice g and grant_id to g, set rr_ptr to (g+1) mod NUM_REQ, and go to WAIT_ARGS.
REQ-022 req_read SHALL be zero-hot or one-hot, and SHALL never be asserted for an empty requester or outside the grant cycle.
REQ-023 In WAIT_ARGS, when args_ready=1, the block SHALL set ap_start to 1 on the next edge and go to WAIT_READY; with args_ready held high, ap_start SHALL rise 2 edges after req_empty is sampled low.
REQ-024 In WAIT_READY, ap_start SHALL stay 1 until ap_ready is sampled high; on that edge, ap_start SHALL go to 0 and the state SHALL go to WAIT_DONE.
REQ-025 If ap_ready and ap_done are sampled high on the same edge in WAIT_READY, the block SHALL pulse req_done[grant_id] and go directly to IDLE.
REQ-026 In WAIT_DONE, on ap_done=1, the block SHALL pulse req_done[grant_id] for one cycle and go to IDLE.
REQ-027 The block SHALL ignore ap_done in IDLE and in WAIT_ARGS.
REQ-028 The earliest next grant SHALL occur on the edge after the return to IDLE (no back-to-back overlap).
REQ-029 cmd_out and grant_id SHALL hold their values until the next grant.

Reset
REQ-030 rstn low SHALL immediately force state=IDLE, rr_ptr=0, req_read=0, ap_start=0, req_done=0, cmd_out=0, grant_id=0, busy=0 and timeout_err=0, independent of clk.
REQ-031 Reset asserted mid-job SHALL abandon the job: no req_done pulse, and ap_start SHALL fall asynchronously.
REQ-032 After rstn deasserts, arbitration SHALL begin at requester 0.

Configuration
REQ-033 With macro CMD_ARB_TIMEOUT_EN defined, a 16-bit counter SHALL clear on entry to WAIT_READY and increment each cycle in WAIT_READY and WAIT_DONE.
REQ-034 With CMD_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES, the block SHALL set ap_start=0, set timeout_err=1 (sticky until reset), go to IDLE, and emit no req_done pulse.
REQ-035 With CMD_ARB_TIMEOUT_EN undefined, the block SHALL have no counter, timeout_err SHALL be tied to 0, and the block SHALL wait indefinitely.

Verification
REQ-036 The bench SHALL cover: only req 2 non-empty, args_ready=1 -> req_read=0100 for one cycle, grant_id=2, ap_start high 2 edges later.
REQ-037 The bench SHALL cover: all 4 requesters continuously non-empty, 8 jobs -> grant order 0,1,2,3,0,1,2,3 with req_done matching each grant.
REQ-038 The bench SHALL cover: args_ready low for 10 cycles after the grant -> ap_start stays 0 and busy=1; ap_start rises on the edge after args_ready rises.
REQ-039 The bench SHALL cover: ap_ready and ap_done high on the same cycle -> single req_done pulse, state returns to IDLE, no WAIT_DONE cycle.
REQ-040 The bench SHALL cover: rstn pulsed low during WAIT_DONE -> all outputs 0 immediately, no req_done, next grant goes to req 0.
REQ-041 The bench SHALL cover: CMD_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=20, ap_done never asserted -> timeout_err=1 after 20 cycles, state returns to IDLE, flag stays set through later jobs.
